// File: rtl/instruction_fetch_if.sv
// Purpose: groups the fetch stage's instruction-memory handshake and IF/ID decode-side signals.
// Ports: master = fetch stage (drives imem_req/imem_addr and the IF/ID outputs);
//        slave = memory/decode side (drives imem_ready/imem_rdata, stall_d, redirect, redirect_pc).
interface instruction_fetch_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic        stall_d;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic [31:0] instr_d;
  logic [31:0] pc_plus_four_d;
  logic        valid_d;

  modport master (
    output imem_req, imem_addr, instr_d, pc_plus_four_d, valid_d,
    input  imem_ready, imem_rdata, stall_d, redirect, redirect_pc
  );

  modport slave (
    input  imem_req, imem_addr, instr_d, pc_plus_four_d, valid_d,
    output imem_ready, imem_rdata, stall_d, redirect, redirect_pc
  );
endinterface

// File: rtl/instruction_fetch.sv
// Purpose: fetch stage plus IF/ID register; one-word hold buffer absorbs decode stalls, redirect flushes.
// Latency: 1 cycle from imem_ready to IF/ID; 1 instr/cycle with zero-wait memory; 2-cycle bubble on redirect.
// Backpressure: stall_d freezes IF/ID; a word returning under stall parks in the hold buffer (imem_req drops).
// Ports: clk, rst (async active-high), bus (instruction_fetch_if.master).
// Option: define BRANCH_DELAY_SLOT_EN to deliver the delay-slot instruction before jumping.
module instruction_fetch #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
  input logic                 clk,
  input logic                 rst,
  instruction_fetch_if.master bus
);

  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_HOLD  = 2'd1,
    S_REDIR = 2'd2
  } state_t;

  state_t      state, state_nxt;
  logic [31:0] pc, pc_inc, redir_tgt, jump_tgt;
  logic [31:0] hold_instr, hold_pc4;
  logic [31:0] instr_q, pc4_q;
  logic        valid_q, req_q;
  logic        take_redir, flush, jump_now;
  logic        accept_fetch, accept_hold, accept, capture;

  assign pc_inc     = pc + 32'd4;              // wraps mod 2^32
  assign redir_tgt  = bus.redirect_pc & ~32'd3;
  assign take_redir = bus.redirect & ~bus.stall_d;
  assign accept     = accept_fetch | accept_hold;

`ifdef BRANCH_DELAY_SLOT_EN
  // Redirect is remembered until the delay-slot instruction is accepted;
  // a redirect in the very cycle of acceptance jumps straight away.
  logic        target_pending;
  logic [31:0] target_q;

  assign flush    = 1'b0;
  assign jump_now = take_redir | target_pending;
  assign jump_tgt = take_redir ? redir_tgt : target_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      target_pending <= 1'b0;
      target_q       <= RESET_PC;
    end else if (accept) begin
      target_pending <= 1'b0;
    end else if (take_redir) begin
      target_pending <= 1'b1;
      target_q       <= redir_tgt;
    end
  end
`else
  assign flush    = take_redir;
  assign jump_now = 1'b0;
  assign jump_tgt = redir_tgt;
`endif

  // State register; imem_req is a flop decoded from the next state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_REDIR;
      req_q <= 1'b0;
    end else begin
      state <= state_nxt;
      req_q <= (state_nxt == S_FETCH);
    end
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      S_FETCH: begin
        if (flush)                  state_nxt = S_REDIR;
        else if (capture)           state_nxt = S_HOLD;
        else if (accept && jump_now) state_nxt = S_REDIR;
      end
      S_HOLD: begin
        if (flush)       state_nxt = S_REDIR;
        else if (accept) state_nxt = jump_now ? S_REDIR : S_FETCH;
      end
      S_REDIR: state_nxt = flush ? S_REDIR : S_FETCH;
      default: state_nxt = S_REDIR;
    endcase
  end

  // Output/control decode. imem_ready only matters in FETCH, where imem_req is
  // high, so a stray response while imem_req=0 never reaches the datapath.
  always_comb begin
    accept_fetch = 1'b0;
    accept_hold  = 1'b0;
    capture      = 1'b0;
    case (state)
      S_FETCH: begin
        accept_fetch = bus.imem_ready & ~bus.stall_d & ~flush;
        capture      = bus.imem_ready & bus.stall_d;
      end
      S_HOLD:  accept_hold = ~bus.stall_d & ~flush;
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc         <= RESET_PC;
      hold_instr <= '0;
      hold_pc4   <= '0;
      instr_q    <= NOP_INSTR;
      pc4_q      <= '0;
      valid_q    <= 1'b0;
    end else begin
      if (flush)       pc <= redir_tgt;
      else if (accept) pc <= jump_now ? jump_tgt : pc_inc;

      if (flush) begin
        hold_instr <= '0;
        hold_pc4   <= '0;
      end else if (capture) begin
        hold_instr <= bus.imem_rdata;
        hold_pc4   <= pc_inc;
      end

      // Anything other than an accepted word (including a flush) is a bubble.
      if (!bus.stall_d) begin
        if (accept_fetch) begin
          instr_q <= bus.imem_rdata;
          pc4_q   <= pc_inc;
          valid_q <= 1'b1;
        end else if (accept_hold) begin
          instr_q <= hold_instr;
          pc4_q   <= hold_pc4;
          valid_q <= 1'b1;
        end else begin
          instr_q <= NOP_INSTR;
          valid_q <= 1'b0;
        end
      end
    end
  end

  assign bus.imem_req       = req_q;
  assign bus.imem_addr      = pc;
  assign bus.instr_d        = instr_q;
  assign bus.pc_plus_four_d = pc4_q;
  assign bus.valid_d        = valid_q;

endmodule

// File: tb/tb_instruction_fetch.sv
// Purpose: directed self-checking bench for instruction_fetch.
// Memory returns addr ^ 32'hA5A5_0000 combinationally unless a fixed word is forced.
// Ports: drives the slave side of instruction_fetch_if; clk/rst generated locally.
module tb_instruction_fetch;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ready_en = 1'b0;
  logic        force_en = 1'b0;
  logic [31:0] force_dat = 32'h0;
  int          n_chk = 0;
  int          n_fail = 0;

  localparam logic [31:0] MEM_KEY = 32'hA5A5_0000;

  instruction_fetch_if bus ();

  instruction_fetch dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  assign bus.imem_ready = ready_en;
  assign bus.imem_rdata = force_en ? force_dat : (bus.imem_addr ^ MEM_KEY);

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Advance one clock and settle just after the edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_ifid(input string tag, input logic v, input logic [31:0] ins, input logic [31:0] p4);
    chk({tag, ".valid"}, {31'd0, bus.valid_d}, {31'd0, v});
    chk({tag, ".instr"}, bus.instr_d, ins);
    chk({tag, ".pc4"},   bus.pc_plus_four_d, p4);
  endtask

  initial begin
    bus.stall_d     = 1'b0;
    bus.redirect    = 1'b0;
    bus.redirect_pc = 32'h0;
    ready_en        = 1'b1;

    // Reset values
    repeat (2) @(posedge clk);
    #1;
    chk("rst.req", {31'd0, bus.imem_req}, 32'd0);
    chk("rst.addr", bus.imem_addr, 32'h0);
    chk_ifid("rst", 1'b0, 32'h0, 32'h0);

    // Release; request rises one cycle later, then 1 instr/cycle
    @(negedge clk);
    rst = 1'b0;
    cyc();
    chk("rel.req", {31'd0, bus.imem_req}, 32'd1);
    chk("rel.addr", bus.imem_addr, 32'h0);
    chk("rel.valid", {31'd0, bus.valid_d}, 32'd0);
    cyc();
    chk_ifid("s0", 1'b1, 32'hA5A5_0000, 32'h4);
    chk("s0.addr", bus.imem_addr, 32'h4);
    cyc();
    chk_ifid("s1", 1'b1, 32'hA5A5_0004, 32'h8);
    chk("s1.addr", bus.imem_addr, 32'h8);
    cyc();
    chk_ifid("s2", 1'b1, 32'hA5A5_0008, 32'hC);
    chk("s2.addr", bus.imem_addr, 32'hC);

    // Memory wait: three bubbles, address held
    ready_en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("wait.addr", bus.imem_addr, 32'hC);
      chk("wait.valid", {31'd0, bus.valid_d}, 32'd0);
      chk("wait.instr", bus.instr_d, 32'h0);
    end
    ready_en = 1'b1;
    cyc();
    chk_ifid("wait.done", 1'b1, 32'hA5A5_000C, 32'h10);
    chk("wait.done.addr", bus.imem_addr, 32'h10);

    // Stall while 0x2402_0005 returns -> HOLD, IF/ID frozen
    bus.stall_d = 1'b1;
    force_en    = 1'b1;
    force_dat   = 32'h2402_0005;
    cyc();
    chk("hold.req", {31'd0, bus.imem_req}, 32'd0);
    chk("hold.addr", bus.imem_addr, 32'h10);
    chk_ifid("hold.frz", 1'b1, 32'hA5A5_000C, 32'h10);
    force_dat = 32'hDEAD_BEEF;     // stray ready while req=0 must be ignored
    cyc();
    chk_ifid("hold.frz2", 1'b1, 32'hA5A5_000C, 32'h10);
    bus.stall_d = 1'b0;
    ready_en    = 1'b0;
    force_en    = 1'b0;
    cyc();
    chk_ifid("hold.out", 1'b1, 32'h2402_0005, 32'h14);
    chk("hold.out.addr", bus.imem_addr, 32'h14);
    chk("hold.out.req", {31'd0, bus.imem_req}, 32'd1);
    cyc();
    chk("hold.after.valid", {31'd0, bus.valid_d}, 32'd0);
    chk("hold.after.addr", bus.imem_addr, 32'h14);

    // Redirect with same-cycle response: response dropped, 2 bubbles
    ready_en        = 1'b1;
    bus.redirect    = 1'b1;
    bus.redirect_pc = 32'h0040_0103;
    cyc();
    bus.redirect = 1'b0;
    chk("redir.b1.valid", {31'd0, bus.valid_d}, 32'd0);
    chk("redir.b1.instr", bus.instr_d, 32'h0);
    chk("redir.b1.req", {31'd0, bus.imem_req}, 32'd0);
    chk("redir.addr", bus.imem_addr, 32'h0040_0100);
    cyc();
    chk("redir.b2.valid", {31'd0, bus.valid_d}, 32'd0);
    chk("redir.b2.req", {31'd0, bus.imem_req}, 32'd1);
    chk("redir.b2.addr", bus.imem_addr, 32'h0040_0100);
    cyc();
    chk_ifid("redir.tgt", 1'b1, 32'hA5E5_0100, 32'h0040_0104);

    // Wrap at 0xFFFF_FFFC
    bus.redirect    = 1'b1;
    bus.redirect_pc = 32'hFFFF_FFFC;
    cyc();
    bus.redirect = 1'b0;
    chk("wrap.addr0", bus.imem_addr, 32'hFFFF_FFFC);
    cyc();
    cyc();
    chk_ifid("wrap", 1'b1, 32'h5A5A_FFFC, 32'h0);
    chk("wrap.addr", bus.imem_addr, 32'h0);

    // Redirect ignored under stall
    bus.stall_d     = 1'b1;
    bus.redirect    = 1'b1;
    bus.redirect_pc = 32'h0000_0100;
    ready_en        = 1'b0;
    cyc();
    chk("stredir.addr", bus.imem_addr, 32'h0);
    chk_ifid("stredir", 1'b1, 32'h5A5A_FFFC, 32'h0);
    bus.stall_d  = 1'b0;
    bus.redirect = 1'b0;
    ready_en     = 1'b1;
    cyc();
    chk_ifid("stredir.go", 1'b1, 32'hA5A5_0000, 32'h4);

    // Reset asserted mid-HOLD
    bus.stall_d = 1'b1;
    cyc();
    chk("mrst.hold.req", {31'd0, bus.imem_req}, 32'd0);
    rst = 1'b1;
    #2;
    chk("mrst.req", {31'd0, bus.imem_req}, 32'd0);
    chk("mrst.addr", bus.imem_addr, 32'h0);
    chk_ifid("mrst", 1'b0, 32'h0, 32'h0);
    @(negedge clk);
    rst         = 1'b0;
    bus.stall_d = 1'b0;
    cyc();
    chk("mrst.rel.req", {31'd0, bus.imem_req}, 32'd1);
    chk("mrst.rel.addr", bus.imem_addr, 32'h0);

`ifdef BRANCH_DELAY_SLOT_EN
    // Instr@0x10 in IF/ID redirects; delay slot @0x14 delivered, then target
    repeat (5) cyc();
    chk_ifid("ds.br", 1'b1, 32'hA5A5_0010, 32'h14);
    bus.redirect    = 1'b1;
    bus.redirect_pc = 32'h0040_0100;
    cyc();
    bus.redirect = 1'b0;
    chk_ifid("ds.slot", 1'b1, 32'hA5A5_0014, 32'h18);
    chk("ds.addr", bus.imem_addr, 32'h0040_0100);
    cyc();
    chk("ds.b.valid", {31'd0, bus.valid_d}, 32'd0);
    cyc();
    chk_ifid("ds.tgt", 1'b1, 32'hA5E5_0100, 32'h0040_0104);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
